pattern_seq_ctrl: RTL and testbench



---
 rtl/pattern_seq_ctrl.sv | 82 ++++++++
 tb/tb_pattern_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_ctrl.sv
// Streams a fixed table of W-bit patterns over valid/ready, repeating the
// table a run-time number of passes, with stall, abort and done handling.
module pattern_seq_ctrl #(
  parameter int             W       = 2,
  parameter int             N       = 4,
  parameter logic [N*W-1:0] PATTERN = 8'h39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [3:0]   reps_i,
  input  logic         abort_i,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         busy,
  output logic         done
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [3:0]    pass;
  logic [3:0]    reps;
  logic          at_end;
  logic          last;

  // idx wraps at N-1, which need not be a power of two.
  assign at_end = (idx == IW'(N - 1));
  assign last   = at_end && (pass == reps - 4'd1);

  // Outputs decode state registers only, so reset clears them immediately.
  assign o_valid = (state == RUN);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign o_last  = o_valid && last;
  assign o_data  = o_valid ? PATTERN[int'(idx)*W +: W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      pass  <= '0;
      reps  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            idx  <= '0;
            pass <= '0;
            reps <= reps_i;
            state <= (reps_i != 4'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          // Abort wins over completion, even on the final accepted beat.
          if (abort_i) begin
            state <= IDLE;
            idx   <= '0;
            pass  <= '0;
          end else if (o_ready) begin
            if (last) begin
              state <= DONE;
              idx   <= '0;
              pass  <= '0;
            end else if (at_end) begin
              idx  <= '0;
              pass <= pass + 4'd1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench: expected beats are queued at start and popped on each
// accepted beat; a second instance exercises a non-default pattern table.
module tb_pattern_seq_ctrl;
  typedef struct {
    logic [2:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Default instance
  logic       start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b1, tog = 1'b0;
  logic [3:0] reps_a = 4'd0;
  logic       valid_a, last_a, busy_a, done_a;
  logic [1:0] data_a;

  pattern_seq_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .reps_i(reps_a), .abort_i(abort_a),
    .o_valid(valid_a), .o_ready(rdy_a), .o_data(data_a), .o_last(last_a),
    .busy(busy_a), .done(done_a)
  );

  // Override instance: entries 4,5,7
  logic       start_b = 1'b0;
  logic [3:0] reps_b = 4'd0;
  logic       valid_b, last_b, busy_b, done_b;
  logic [2:0] data_b;

  pattern_seq_ctrl #(.W(3), .N(3), .PATTERN(9'o754)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .reps_i(reps_b), .abort_i(1'b0),
    .o_valid(valid_b), .o_ready(1'b1), .o_data(data_b), .o_last(last_b),
    .busy(busy_b), .done(done_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0;
  int   start_cyc = 0;

  logic [1:0] tbl_a [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [2:0] tbl_b [3] = '{3'd4, 3'd5, 3'd7};

  always begin
    @(posedge clk);
    #1;
    rdy_a = tog ? ~rdy_a : 1'b1;
  end

  // Every valid cycle must present the queue head; stalls keep it there.
  always @(negedge clk) begin
    if (valid_a) begin
      if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
      else begin
        chk("a_data", data_a, qa[0].d);
        chk("a_last", last_a, qa[0].l);
        if (rdy_a) void'(qa.pop_front());
      end
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
      else begin
        chk("b_data", data_b, qb[0].d);
        chk("b_last", last_b, qb[0].l);
        void'(qb.pop_front());
      end
    end
    if (done_b) done_cnt_b++;
  end

  task automatic push_a(input int reps, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      exp_t e;
      e.d = {1'b0, tbl_a[i % 4]};
      e.l = (i == 4 * reps - 1);
      qa.push_back(e);
    end
  endtask

  task automatic start_run_a(input logic [3:0] r);
    reps_a  = r;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a   = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done_a(input string tag, input int d0, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt_a != d0) break;
    end
    chk({tag, "_done_seen"}, (done_cnt_a != d0), 1);
    #1;
  endtask

  initial begin
    int d0;
    #23;
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reps=1, ready held
    d0 = done_cnt_a;
    push_a(1, 4);
    start_run_a(4'd1);
    wait_done_a("r1", d0, 20);
    chk("r1_latency", done_cyc_a - start_cyc, 4);
    chk("r1_done_once", done_cnt_a - d0, 1);
    chk("r1_busy_after", busy_a, 0);
    chk("r1_q_empty", qa.size(), 0);

    // reps=2, ready toggling
    tog = 1'b1;
    d0 = done_cnt_a;
    push_a(2, 8);
    start_run_a(4'd2);
    wait_done_a("r2", d0, 60);
    tog = 1'b0;
    chk("r2_done_once", done_cnt_a - d0, 1);
    chk("r2_q_empty", qa.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // reps=0: no beats, done next cycle
    d0 = done_cnt_a;
    start_run_a(4'd0);
    wait_done_a("r0", d0, 5);
    chk("r0_latency", done_cyc_a - start_cyc, 0);
    chk("r0_idle", valid_a, 0);
    @(posedge clk);
    #1;

    // reps=3, abort on beat 5
    d0 = done_cnt_a;
    push_a(3, 5);
    for (int i = 0; i < 5; i++) qa[i].l = 1'b0;
    start_run_a(4'd3);
    repeat (4) @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk);
    #1 abort_a = 1'b0;
    chk("ab_valid", valid_a, 0);
    chk("ab_busy", busy_a, 0);
    chk("ab_q_empty", qa.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ab_no_done", done_cnt_a - d0, 0);
    push_a(1, 4);
    start_run_a(4'd1);
    wait_done_a("ab_restart", d0, 20);
    chk("ab_restart_q", qa.size(), 0);
    @(posedge clk);
    #1;

    // async reset during beat 3
    d0 = done_cnt_a;
    push_a(1, 4);
    start_run_a(4'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", valid_a, 0);
    chk("ar_busy", busy_a, 0);
    chk("ar_data", data_a, 0);
    chk("ar_beats_left", qa.size(), 2);
    qa.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ar_no_done", done_cnt_a - d0, 0);
    chk("ar_idle", valid_a, 0);

    // override table, start pulsed mid-run is ignored
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.d = tbl_b[i];
      e.l = (i == 2);
      qb.push_back(e);
    end
    reps_b  = 4'd1;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    chk("b_busy", busy_b, 1);
    @(posedge clk);
    #1;
    start_b = 1'b1;
    reps_b  = 4'd5;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    reps_b  = 4'd1;
    repeat (6) @(posedge clk);
    #1;
    chk("b_q_empty", qb.size(), 0);
    chk("b_done_once", done_cnt_b, 1);
    chk("b_idle", busy_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
